// File: rtl/watch_adjust_cu.sv
// watch_adjust_cu: turns debounced mode/up/down levels into field selects and up/down pulses
//   clk, rst                       clock, asynchronous active-high reset
//   i_btn_mode/i_btn_up/i_btn_down debounced button levels
//   o_sec/o_min/o_hour             one-hot field select (all 0 in RUN)
//   o_updown                       10 = up pulse, 01 = down pulse, 00 = none
//   o_edit                         high in any SET state
//   o_blink                        blink phase for the selected digits, 0 in RUN
module watch_adjust_cu #(
  parameter int REPEAT_DELAY = 50_000_000,
  parameter int REPEAT_RATE  = 10_000_000,
  parameter int TIMEOUT      = 1_000_000_000,
  parameter int BLINK_HALF   = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_btn_mode,
  input  logic       i_btn_up,
  input  logic       i_btn_down,
  output logic       o_sec,
  output logic       o_min,
  output logic       o_hour,
  output logic [1:0] o_updown,
  output logic       o_edit,
  output logic       o_blink
);
  typedef enum logic [1:0] {RUN, SET_SEC, SET_MIN, SET_HOUR} state_t;
  localparam int RW = $clog2(REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE);
  localparam int TW = $clog2(TIMEOUT);
  localparam int BW = $clog2(BLINK_HALF);
  localparam logic [RW-1:0] DLY_END = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_END = RW'(REPEAT_RATE - 1);
  localparam logic [TW-1:0] TO_END = TW'(TIMEOUT - 1);
  localparam logic [BW-1:0] BLINK_END = BW'(BLINK_HALF - 1);
  state_t state, nxt;
  logic prev_mode, prev_up, prev_down;
  logic rep_active, rep_first, rep_dir, blocked;
  logic [RW-1:0] rep_cnt;
  logic [TW-1:0] to_cnt;
  logic [BW-1:0] blink_cnt;
  logic mode_rise, any_rise, in_set, keep, fresh, rep_hit, fire, to_hit, entering, blink_hit;
  // keep: a single up/down is held in a SET state and may generate pulses.
  // blocked: a button held across a mode step must be released before it acts again.
  always_comb begin
    mode_rise = i_btn_mode & ~prev_mode;
    any_rise = mode_rise | (i_btn_up & ~prev_up) | (i_btn_down & ~prev_down);
    in_set = state != RUN;
    keep = in_set & ~mode_rise & ~blocked & (i_btn_up ^ i_btn_down);
    fresh = ~rep_active | (rep_dir != i_btn_up);
    rep_hit = rep_cnt == (rep_first ? DLY_END : RATE_END);
    fire = keep & (fresh | rep_hit);
    to_hit = in_set & ~any_rise & ~fire & (to_cnt == TO_END);
    nxt = !in_set ? (mode_rise ? SET_SEC : RUN) :
          mode_rise ? (state == SET_HOUR ? RUN : state_t'(state + 2'd1)) :
          to_hit ? RUN : state;
    entering = (nxt != RUN) && (nxt != state);
    blink_hit = blink_cnt == BLINK_END;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= RUN;
      prev_mode <= 1'b0;
      prev_up <= 1'b0;
      prev_down <= 1'b0;
      rep_active <= 1'b0;
      rep_first <= 1'b0;
      rep_dir <= 1'b0;
      blocked <= 1'b0;
      rep_cnt <= '0;
      to_cnt <= '0;
      blink_cnt <= '0;
      o_sec <= 1'b0;
      o_min <= 1'b0;
      o_hour <= 1'b0;
      o_updown <= 2'b00;
      o_edit <= 1'b0;
      o_blink <= 1'b0;
    end else begin
      prev_mode <= i_btn_mode;
      prev_up <= i_btn_up;
      prev_down <= i_btn_down;
      state <= nxt;
      o_sec <= nxt == SET_SEC;
      o_min <= nxt == SET_MIN;
      o_hour <= nxt == SET_HOUR;
      o_edit <= nxt != RUN;
      o_updown <= fire ? {i_btn_up, i_btn_down} : 2'b00;
      blocked <= (~in_set | mode_rise | blocked) & (i_btn_up | i_btn_down);
      rep_active <= keep;
      rep_dir <= i_btn_up;
      rep_first <= fresh | (rep_first & ~rep_hit);
      rep_cnt <= (~keep | fire) ? '0 : rep_cnt + 1'b1;
      to_cnt <= (~in_set | any_rise | fire | to_hit) ? '0 : to_cnt + 1'b1;
      blink_cnt <= (nxt == RUN || entering || blink_hit) ? '0 : blink_cnt + 1'b1;
      o_blink <= nxt == RUN ? 1'b0 : entering ? 1'b1 : o_blink ^ blink_hit;
    end
endmodule

// File: tb/tb_watch_adjust_cu.sv
// tb_watch_adjust_cu: directed and random stimulus against a timing-rule model of watch_adjust_cu
module tb_watch_adjust_cu;
  localparam int RD = 8, RR = 4, TO = 32, BH = 5;
  logic clk = 1'b0, rst = 1'b1, btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic o_sec, o_min, o_hour, o_edit, o_blink;
  logic [1:0] o_updown;
  int total = 0, bad = 0, cyc_n = 0, base = 0;
  int plog[$];
  int pval[$];
  watch_adjust_cu #(.REPEAT_DELAY(RD), .REPEAT_RATE(RR), .TIMEOUT(TO), .BLINK_HALF(BH)) dut (
    .clk(clk), .rst(rst), .i_btn_mode(btn_mode), .i_btn_up(btn_up), .i_btn_down(btn_down),
    .o_sec(o_sec), .o_min(o_min), .o_hour(o_hour), .o_updown(o_updown), .o_edit(o_edit),
    .o_blink(o_blink));
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc_n++;
  end
  // model: mode 0=RUN 1=SEC 2=MIN 3=HOUR; hold = cycles since the initial pulse of the
  // current solo press (-1 when none); idle = cycles without rise or pulse; since = cycles in field
  int mode = 0, hold = -1, hdir = 0, idle = 0, since = 0, pmode = 0;
  bit pm, pu, pd, need_rel, pulse, m, u, d, mr, ur, dr;
  logic [6:0] exp_v = '0;
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      mode = 0; hold = -1; idle = 0; since = 0;
      pm = 0; pu = 0; pd = 0; need_rel = 0; exp_v = '0;
    end else begin
      m = btn_mode; u = btn_up; d = btn_down;
      mr = m & !pm; ur = u & !pu; dr = d & !pd;
      pulse = 0;
      pmode = mode;
      if (mr) begin
        mode = (mode + 1) % 4;
        need_rel = u | d;
        hold = -1;
        idle = 0;
      end else if (mode != 0) begin
        if (!(u | d)) need_rel = 0;
        if ((u ^ d) && !need_rel) begin
          if (hold < 0 || hdir != int'(u)) begin
            hold = 0;
            hdir = int'(u);
          end else hold++;
          pulse = (hold == 0) || (hold >= RD && (hold - RD) % RR == 0);
        end else hold = -1;
        if (ur | dr | pulse) idle = 0; else idle++;
        if (idle == TO) mode = 0;
      end
      if (mode == 0 || mode != pmode) since = 0; else since++;
      exp_v = {mode == 1, mode == 2, mode == 3, pulse ? (u ? 2'b10 : 2'b01) : 2'b00,
               mode != 0, mode != 0 && ((since / BH) % 2 == 0)};
      pm = m; pu = u; pd = d;
    end
  end
  initial forever begin
    @(negedge clk);
    total++;
    if ({o_sec, o_min, o_hour, o_updown, o_edit, o_blink} !== exp_v) begin
      bad++;
      $display("FAIL cycle %0d: dut sel/ud/edit/blink=%b model=%b", cyc_n,
               {o_sec, o_min, o_hour, o_updown, o_edit, o_blink}, exp_v);
    end
    if (o_updown != 2'b00) begin
      plog.push_back(cyc_n - base);
      pval.push_back(int'(o_updown));
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1);
  end
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string nm, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, want);
    end
  endtask
  task automatic mark;
    base = cyc_n;
    plog.delete();
    pval.delete();
  endtask
  task automatic goto(input int n);
    @(negedge clk);
    rst = 1'b1; btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (n) begin
      btn_mode = 1'b1; step(3);
      btn_mode = 1'b0; step(3);
    end
  endtask
  int sel_tab[4] = '{4'b1001, 4'b0101, 4'b0011, 4'b0000};
  int rep_tab[7] = '{1, 9, 13, 17, 21, 25, 29};
  int pu_rate, pd_rate, pm_rate;
  initial begin
    step(1);
    chk("reset_outputs", int'({o_sec, o_min, o_hour, o_updown, o_edit, o_blink}), 0);
    rst = 1'b0;
    step(2);
    for (int i = 0; i < 4; i++) begin
      btn_mode = 1'b1; step(3);
      chk($sformatf("select_step%0d", i), int'({o_sec, o_min, o_hour, o_edit}), sel_tab[i]);
      btn_mode = 1'b0; step(3);
    end
    goto(2);
    chk("in_min", int'(o_min), 1);
    mark(); btn_up = 1'b1; step(2); btn_up = 1'b0; step(4);
    chk("tap_up_count", plog.size(), 1);
    if (plog.size() > 0) begin
      chk("tap_up_rel", plog[0], 1);
      chk("tap_up_val", pval[0], 2);
    end
    mark(); btn_down = 1'b1; step(2); btn_down = 1'b0; step(4);
    chk("tap_dn_count", plog.size(), 1);
    if (plog.size() > 0) begin
      chk("tap_dn_rel", plog[0], 1);
      chk("tap_dn_val", pval[0], 1);
    end
    goto(1);
    mark(); btn_up = 1'b1; step(30); btn_up = 1'b0; step(10);
    chk("hold_count", plog.size(), 7);
    for (int i = 0; i < 7; i++)
      if (i < plog.size()) chk($sformatf("hold_rel%0d", i), plog[i], rep_tab[i]);
    goto(3);
    chk("in_hour", int'(o_hour), 1);
    mark(); btn_up = 1'b1; btn_down = 1'b1; step(10);
    chk("both_no_pulse", plog.size(), 0);
    btn_down = 1'b0; step(4); btn_up = 1'b0; step(4);
    chk("both_fresh_count", plog.size(), 1);
    if (plog.size() > 0) begin
      chk("both_fresh_rel", plog[0], 11);
      chk("both_fresh_val", pval[0], 2);
    end
    goto(0);
    mark(); btn_mode = 1'b1;
    for (int r = 1; r <= 34; r++) begin
      step(1);
      if (r == 3) btn_mode = 1'b0;
      if (r == 3) chk("blink_r3", int'(o_blink), 1);
      if (r == 7) chk("blink_r7", int'(o_blink), 0);
      if (r == 12) chk("blink_r12", int'(o_blink), 1);
      if (r == 32) chk("edit_before_timeout", int'(o_edit), 1);
      if (r == 33) chk("after_timeout", int'({o_sec, o_min, o_hour, o_edit, o_blink}), 0);
    end
    goto(2);
    mark(); btn_up = 1'b1; step(12);
    chk("pre_rst_pulses", plog.size(), 2);
    #3 rst = 1'b1;
    #1 chk("rst_async", int'({o_sec, o_min, o_hour, o_updown, o_edit, o_blink}), 0);
    step(2); rst = 1'b0; step(3); btn_up = 1'b0; step(2);
    mark(); btn_up = 1'b1; step(2); btn_up = 1'b0; step(3);
    chk("run_no_pulse", plog.size(), 0);
    chk("run_edit", int'(o_edit), 0);
    for (int s = 0; s < 12; s++) begin
      pu_rate = (s % 3 == 0) ? 4 : (s % 3 == 1) ? 16 : 64;
      pd_rate = (s % 4 == 0) ? 6 : 40;
      pm_rate = (s % 2 == 0) ? 25 : 90;
      for (int c = 0; c < 250; c++) begin
        @(negedge clk);
        btn_mode = ($urandom_range(0, pm_rate - 1) == 0);
        if ($urandom_range(0, pu_rate - 1) == 0) btn_up = ~btn_up;
        if ($urandom_range(0, pd_rate - 1) == 0) btn_down = ~btn_down;
        if ($urandom_range(0, 599) == 0) begin
          #3 rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
        end
      end
    end
    btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    step(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
